ps2_scancode_receiver: RTL and testbench

- Upstream of the keyboard matrix emulation: deserialises the PS/2 keyboard clock/data lines into scan-code bytes.
- Folds the E0 (extended) and F0 (break) prefixes into flags on the following code.
- Presents one byte per key event with a single-cycle valid strobe; the keyboard block converts these into BBC row/column state.
- Runs on the system clock with the 1 MHz IO enable.

---
 rtl/ps2_scancode_receiver.sv | 203 ++++++++++++++++++++
 tb/tb_ps2_scancode_receiver.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard receiver: deserialises device-to-host frames into scan codes,
// folding E0/F0 prefixes into EXTENDED/RELEASED flags on the next code.
//
// state  | meaning
// IDLE   | waiting for a start bit on a filtered clock falling edge
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking stop bit and parity, then publishing or discarding
module ps2_scancode_receiver #(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 2000
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       CLK_en,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] SCANCODE,
  output logic       EXTENDED,
  output logic       RELEASED,
  output logic       VALID,
  output logic       PARITY_ERR,
  output logic       FRAME_ERR
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t      state_q, state_d;
  logic        clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic        dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic        fclk_q, fclk_d, fdat_q, fdat_d;
  logic [3:0]  fcnt_clk_q, fcnt_clk_d, fcnt_dat_q, fcnt_dat_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic        ext_q, ext_d, rel_q, rel_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [7:0]  code_q, code_d;
  logic        ext_out_q, ext_out_d, rel_out_q, rel_out_d;
  logic        valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
  logic        bit_evt;

  always_comb begin
    state_d    = state_q;
    clk_s1_d   = PS2_CLK;
    clk_s2_d   = clk_s1_q;
    dat_s1_d   = PS2_DATA;
    dat_s2_d   = dat_s1_q;
    fclk_d     = fclk_q;
    fdat_d     = fdat_q;
    fcnt_clk_d = fcnt_clk_q;
    fcnt_dat_d = fcnt_dat_q;
    bcnt_d     = bcnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    ext_d      = ext_q;
    rel_d      = rel_q;
    tcnt_d     = tcnt_q;
    code_d     = code_q;
    ext_out_d  = ext_out_q;
    rel_out_d  = rel_out_q;
    valid_d    = 1'b0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
    bit_evt    = 1'b0;

    if (CLK_en) begin
      // a line only flips after FILTER_LEN consecutive disagreeing samples
      if (clk_s2_q != fclk_q) begin
        if (fcnt_clk_q == 4'(FILTER_LEN - 1)) begin
          fclk_d     = clk_s2_q;
          fcnt_clk_d = '0;
          bit_evt    = fclk_q;
        end else begin
          fcnt_clk_d = fcnt_clk_q + 4'd1;
        end
      end else begin
        fcnt_clk_d = '0;
      end

      if (dat_s2_q != fdat_q) begin
        if (fcnt_dat_q == 4'(FILTER_LEN - 1)) begin
          fdat_d     = dat_s2_q;
          fcnt_dat_d = '0;
        end else begin
          fcnt_dat_d = fcnt_dat_q + 4'd1;
        end
      end else begin
        fcnt_dat_d = '0;
      end

      if (bit_evt) begin
        tcnt_d = '0;
        case (state_q)
          IDLE: begin
            if (!fdat_q) begin
              state_d = DATA;
              bcnt_d  = '0;
              shift_d = '0;
            end
          end
          DATA: begin
            shift_d = {fdat_q, shift_q[7:1]};
            bcnt_d  = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) state_d = PARITY;
          end
          PARITY: begin
            par_d   = fdat_q;
            state_d = STOP;
          end
          default: begin
            state_d = IDLE;
            if (!fdat_q || !(^{shift_q, par_q})) begin
              perr_d = 1'b1;
              ext_d  = 1'b0;
              rel_d  = 1'b0;
            end else if (shift_q == 8'hE0) begin
              ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
              rel_d = 1'b1;
            end else begin
              code_d    = shift_q;
              ext_out_d = ext_q;
              rel_out_d = rel_q;
              valid_d   = 1'b1;
              ext_d     = 1'b0;
              rel_d     = 1'b0;
            end
          end
        endcase
      end else if (state_q == IDLE) begin
        tcnt_d = '0;
      end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
        // stalled mid-frame: drop the partial byte and any pending prefix
        ferr_d  = 1'b1;
        ext_d   = 1'b0;
        rel_d   = 1'b0;
        tcnt_d  = '0;
        state_d = IDLE;
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= IDLE;
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      fclk_q     <= 1'b1;
      fdat_q     <= 1'b1;
      fcnt_clk_q <= '0;
      fcnt_dat_q <= '0;
      bcnt_q     <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      ext_q      <= 1'b0;
      rel_q      <= 1'b0;
      tcnt_q     <= '0;
      code_q     <= '0;
      ext_out_q  <= 1'b0;
      rel_out_q  <= 1'b0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      fclk_q     <= fclk_d;
      fdat_q     <= fdat_d;
      fcnt_clk_q <= fcnt_clk_d;
      fcnt_dat_q <= fcnt_dat_d;
      bcnt_q     <= bcnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      ext_q      <= ext_d;
      rel_q      <= rel_d;
      tcnt_q     <= tcnt_d;
      code_q     <= code_d;
      ext_out_q  <= ext_out_d;
      rel_out_q  <= rel_out_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign SCANCODE   = code_q;
  assign EXTENDED   = ext_out_q;
  assign RELEASED   = rel_out_q;
  assign VALID      = valid_q;
  assign PARITY_ERR = perr_q;
  assign FRAME_ERR  = ferr_q;

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Randomised and directed frames checked against an event-level model of the
// prefix-folding receiver.
module tb_ps2_scancode_receiver;
  localparam int FL = 4;
  localparam int TO = 2000;

  logic       CLK = 1'b0;
  logic       nRESET = 1'b0;
  logic       CLK_en = 1'b0;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DATA = 1'b1;
  logic [7:0] SCANCODE;
  logic       EXTENDED, RELEASED, VALID, PARITY_ERR, FRAME_ERR;

  int n_assert = 0;
  int n_fail = 0;
  int en_ticks = 0;
  int ferr_tick = 0;
  int fall_tick = 0;
  logic [11:0] obs_q[$];
  logic [11:0] exp_q[$];
  bit ext_m = 1'b0;
  bit rel_m = 1'b0;
  bit mon_prev = 1'b0;

  ps2_scancode_receiver #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .CLK(CLK), .nRESET(nRESET), .CLK_en(CLK_en), .PS2_CLK(PS2_CLK),
    .PS2_DATA(PS2_DATA), .SCANCODE(SCANCODE), .EXTENDED(EXTENDED),
    .RELEASED(RELEASED), .VALID(VALID), .PARITY_ERR(PARITY_ERR),
    .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;
  initial forever begin
    @(negedge CLK);
    CLK_en = ~CLK_en;
  end
  always @(posedge CLK) if (CLK_en) en_ticks++;

  // Event recorder: kind 1=VALID {ext,rel,code}, 2=PARITY_ERR, 3=FRAME_ERR
  always @(negedge CLK) begin
    int npulse;
    npulse = int'(VALID) + int'(PARITY_ERR) + int'(FRAME_ERR);
    if (npulse != 0) begin
      n_assert++;
      if (npulse > 1 || mon_prev) begin
        n_fail++;
        $display("FAIL pulse_shape got V=%b P=%b F=%b prev_cycle=%b, required one isolated single-cycle pulse",
                 VALID, PARITY_ERR, FRAME_ERR, mon_prev);
      end
      if (VALID) obs_q.push_back({2'd1, EXTENDED, RELEASED, SCANCODE});
      if (PARITY_ERR) obs_q.push_back({2'd2, 10'd0});
      if (FRAME_ERR) begin
        obs_q.push_back({2'd3, 10'd0});
        ferr_tick = en_ticks;
      end
    end
    mon_prev = (npulse != 0);
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      while (!CLK_en) @(posedge CLK);
    end
    #1;
  endtask

  // 80-tick bit period: data set, 20 high, 40 low, 20 high
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      PS2_DATA = bits[i];
      wait_ticks(20);
      PS2_CLK = 1'b0;
      fall_tick = en_ticks;
      wait_ticks(40);
      PS2_CLK = 1'b1;
      wait_ticks(20);
    end
    PS2_DATA = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    send_bits({~bad_stop, par, b, 1'b0}, 11);
    wait_ticks(30);
    if (bad_par || bad_stop) begin
      exp_q.push_back({2'd2, 10'd0});
      ext_m = 1'b0;
      rel_m = 1'b0;
    end else if (b == 8'hE0) begin
      ext_m = 1'b1;
    end else if (b == 8'hF0) begin
      rel_m = 1'b1;
    end else begin
      exp_q.push_back({2'd1, ext_m, rel_m, b});
      ext_m = 1'b0;
      rel_m = 1'b0;
    end
  endtask

  task automatic test_reset();
    nRESET = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_assert++;
    if (SCANCODE !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_scancode got %h want 00", SCANCODE);
    end
    n_assert++;
    if ({EXTENDED, RELEASED, VALID, PARITY_ERR, FRAME_ERR} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 00000", {EXTENDED, RELEASED, VALID, PARITY_ERR, FRAME_ERR});
    end
    nRESET = 1'b1;
    wait_ticks(10);
  endtask

  task automatic test_single();
    send_frame(8'h1C, 0, 0);
    n_assert++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL single_count got %0d want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL single_event[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
    wait_ticks(50);
    n_assert++;
    if ({SCANCODE, EXTENDED, RELEASED, VALID} !== {8'h1C, 3'b000}) begin
      n_fail++;
      $display("FAIL single_hold got %h/%b%b%b want 1C/000", SCANCODE, EXTENDED, RELEASED, VALID);
    end
  endtask

  task automatic test_prefixes();
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    send_frame(8'h75, 0, 0);
    n_assert++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL prefix_count got %0d want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL prefix_event[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_parity();
    send_frame(8'h1C, 1, 0);
    send_frame(8'h32, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'(($urandom_range(0, 255))), 1, 0);
    send_frame(8'h32, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h44, 0, 1);
    send_frame(8'h32, 0, 0);
    n_assert++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL parity_count got %0d want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL parity_event[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_timeout();
    send_frame(8'hE0, 0, 0);
    send_bits({3'b111, 8'b0001_0110}, 6);
    wait_ticks(2500);
    exp_q.push_back({2'd3, 10'd0});
    ext_m = 1'b0;
    rel_m = 1'b0;
    // two synchroniser flops cost one tick, the filter FILTER_LEN ticks
    n_assert++;
    if (ferr_tick - fall_tick != TO + FL + 1) begin
      n_fail++;
      $display("FAIL timeout_delay got %0d ticks want %0d", ferr_tick - fall_tick, TO + FL + 1);
    end
    send_frame(8'h29, 0, 0);
    n_assert++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL timeout_count got %0d want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL timeout_event[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_glitch_reset();
    PS2_CLK = 1'b0;
    wait_ticks(2);
    PS2_CLK = 1'b1;
    wait_ticks(20);
    PS2_CLK = 1'b0;
    wait_ticks(FL - 1);
    PS2_CLK = 1'b1;
    wait_ticks(20);
    send_frame(8'h12, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_bits({7'b1111111, 4'b0110}, 4);
    #2 nRESET = 1'b0;
    #1;
    n_assert++;
    if ({SCANCODE, EXTENDED, RELEASED, VALID, PARITY_ERR, FRAME_ERR} !== 13'd0) begin
      n_fail++;
      $display("FAIL async_reset got %h/%b%b%b%b%b want 00/00000", SCANCODE, EXTENDED, RELEASED,
               VALID, PARITY_ERR, FRAME_ERR);
    end
    n_assert++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL glitch_count got %0d want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL glitch_event[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
    ext_m = 1'b0;
    rel_m = 1'b0;
    repeat (4) @(posedge CLK);
    #1 nRESET = 1'b1;
    wait_ticks(10);
    send_frame(8'h5A, 0, 0);
    n_assert++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL post_reset_count got %0d want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL post_reset_event[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    for (int k = 0; k < 12; k++) begin
      int sel;
      logic [7:0] b;
      bit bp, bs;
      sel = int'($urandom_range(0, 99));
      b = 8'($urandom_range(0, 255));
      if (sel < 20) b = 8'hE0;
      else if (sel < 35) b = 8'hF0;
      bp = ($urandom_range(0, 9) == 0);
      bs = ($urandom_range(0, 14) == 0);
      send_frame(b, bp, bs);
    end
    n_assert++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL random_count got %0d want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL random_event[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_prefixes();
    test_parity();
    test_timeout();
    test_glitch_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
